// File: rtl/ray_marcher_pkg.sv
// ray_marcher_pkg: shared fixed-point types, state encoding and arithmetic helpers
package ray_marcher_pkg;
    localparam int BITS  = 32;
    localparam int FIXED = 16;

    typedef logic signed [BITS-1:0] fix_t;

    typedef struct packed {
        fix_t x;
        fix_t y;
        fix_t z;
    } vec3;

    typedef enum logic [2:0] {S_IDLE, S_POINT, S_ISSUE, S_WAIT, S_EVAL, S_DONE} state_t;

    function automatic fix_t to_fixed(input int v);
        return fix_t'(v) <<< FIXED;
    endfunction

    function automatic fix_t fx_mul(input fix_t a, input fix_t b);
        logic signed [2*BITS-1:0] p;
        p = (2*BITS)'(a) * (2*BITS)'(b);
        p = p >>> FIXED;
        return p[BITS-1:0];
    endfunction
endpackage

// File: rtl/ray_marcher_point_calc.sv
// ray_point_calc: registered ray sample point p = o + t*d, loaded only when enabled
module ray_point_calc
    import ray_marcher_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic i_en,
    input  vec3  i_o,
    input  vec3  i_d,
    input  fix_t i_t,
    output vec3  o_p
);
    vec3 r_p;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p.x <= i_o.x + fx_mul(i_t, i_d.x);
            r_p.y <= i_o.y + fx_mul(i_t, i_d.y);
            r_p.z <= i_o.z + fx_mul(i_t, i_d.z);
        end
    end

    assign o_p = r_p;
endmodule

// File: rtl/ray_marcher.sv
// ray_marcher: sphere-tracing controller that iterates SDF queries along one ray per request
module ray_marcher
    import ray_marcher_pkg::*;
#(
    parameter int         MAX_STEPS = 64,
    parameter fix_t       MAX_T     = to_fixed(20),
    parameter fix_t       EPS       = 65,
    parameter logic [7:0] BG_RED    = 8'h20,
    parameter logic [7:0] BG_GREEN  = 8'h20,
    parameter logic [7:0] BG_BLUE   = 8'h40
)(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            march_start,
    input  logic [BITS-1:0] ox,
    input  logic [BITS-1:0] oy,
    input  logic [BITS-1:0] oz,
    input  logic [BITS-1:0] dx,
    input  logic [BITS-1:0] dy,
    input  logic [BITS-1:0] dz,
    output logic            sdf_start,
    output logic [BITS-1:0] sdf_x,
    output logic [BITS-1:0] sdf_y,
    output logic [BITS-1:0] sdf_z,
    input  logic            sdf_done,
    input  logic [BITS-1:0] sdf_dist,
    input  logic [7:0]      sdf_red_in,
    input  logic [7:0]      sdf_green_in,
    input  logic [7:0]      sdf_blue_in,
    output logic            march_done,
    output logic            hit,
    output logic [BITS-1:0] t_out,
    output logic [7:0]      steps_out,
    output logic [7:0]      red_out,
    output logic [7:0]      green_out,
    output logic [7:0]      blue_out
);
    state_t      r_state, w_next;
    vec3         r_o, r_d, w_p;
    fix_t        r_t, r_dist, r_t_out, w_t_next;
    logic [7:0]  r_steps, r_steps_out;
    logic [23:0] r_scol, r_col;
    logic        r_hit, w_inside, w_stop;

    ray_point_calc u_point (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .i_en   (r_state == S_POINT),
        .i_o    (r_o),
        .i_d    (r_d),
        .i_t    (r_t),
        .o_p    (w_p)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_t_next = r_t + r_dist;
        w_inside = r_dist < EPS;
        w_stop   = w_inside || (w_t_next > MAX_T) || (r_steps == 8'(MAX_STEPS));
        w_next   = r_state;
        case (r_state)
            S_IDLE:  w_next = march_start ? S_POINT : S_IDLE;
            S_POINT: w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  w_next = sdf_done ? S_EVAL : S_WAIT;
            S_EVAL:  w_next = w_stop ? S_DONE : S_POINT;
            default: w_next = S_IDLE;
        endcase
    end

    // Results are written on the EVAL->DONE edge so they are already valid while march_done is high.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_o         <= '0;
            r_d         <= '0;
            r_t         <= '0;
            r_dist      <= '0;
            r_steps     <= '0;
            r_scol      <= '0;
            r_hit       <= 1'b0;
            r_t_out     <= '0;
            r_steps_out <= '0;
            r_col       <= '0;
        end else begin
            if (r_state == S_IDLE && march_start) begin
                r_o     <= {ox, oy, oz};
                r_d     <= {dx, dy, dz};
                r_t     <= '0;
                r_steps <= '0;
            end
            if (r_state == S_ISSUE) r_steps <= r_steps + 8'd1;
            if (r_state == S_WAIT && sdf_done) begin
                r_dist <= sdf_dist;
                r_scol <= {sdf_red_in, sdf_green_in, sdf_blue_in};
            end
            if (r_state == S_EVAL) begin
                if (!w_inside) r_t <= w_t_next;
                if (w_stop) begin
                    r_hit       <= w_inside;
                    r_t_out     <= w_inside ? r_t : w_t_next;
                    r_steps_out <= r_steps;
                    r_col       <= w_inside ? r_scol : {BG_RED, BG_GREEN, BG_BLUE};
                end
            end
        end
    end

    assign sdf_start  = r_state == S_ISSUE;
    assign march_done = r_state == S_DONE;
    assign sdf_x      = w_p.x;
    assign sdf_y      = w_p.y;
    assign sdf_z      = w_p.z;
    assign hit        = r_hit;
    assign t_out      = r_t_out;
    assign steps_out  = r_steps_out;
    assign {red_out, green_out, blue_out} = r_col;
endmodule

// File: tb/tb_ray_marcher.sv
// tb_ray_marcher: directed scoreboard bench with a 4-cycle-latency SDF stub
module tb_ray_marcher;
    import ray_marcher_pkg::*;

    localparam int ONE = 65536;

    typedef struct packed {
        logic        hit;
        logic [31:0] t;
        logic [7:0]  steps;
        logic [23:0] col;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        march_start = 1'b0;
    logic [31:0] ox = '0, oy = '0, oz = '0, dx = '0, dy = '0, dz = '0;
    logic        sdf_start;
    logic [31:0] sdf_x, sdf_y, sdf_z;
    logic        sdf_done = 1'b0;
    logic [31:0] sdf_dist = '0;
    logic [7:0]  sdf_red_in = 8'hA1, sdf_green_in = 8'hB2, sdf_blue_in = 8'hC3;
    logic        march_done, hit;
    logic [31:0] t_out;
    logic [7:0]  steps_out, red_out, green_out, blue_out;

    int   checks = 0;
    int   failures = 0;
    int   stub_mode = 0;
    int   stub_cnt = 0;
    fix_t stub_z = '0;
    exp_t sb[$];

    localparam logic [23:0] STUB_COL = 24'hA1B2C3;
    localparam logic [23:0] BG_COL   = 24'h202040;

    always #5 clk_in = ~clk_in;

    ray_marcher #(.MAX_STEPS(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .march_start(march_start),
        .ox(ox), .oy(oy), .oz(oz), .dx(dx), .dy(dy), .dz(dz),
        .sdf_start(sdf_start), .sdf_x(sdf_x), .sdf_y(sdf_y), .sdf_z(sdf_z),
        .sdf_done(sdf_done), .sdf_dist(sdf_dist),
        .sdf_red_in(sdf_red_in), .sdf_green_in(sdf_green_in), .sdf_blue_in(sdf_blue_in),
        .march_done(march_done), .hit(hit), .t_out(t_out), .steps_out(steps_out),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out)
    );

    function automatic logic [31:0] stub_dist(input int mode, input fix_t z);
        case (mode)
            0:       return 32'(5 * ONE - z);
            1:       return 32'(3 * ONE);
            2:       return 32'd655;
            3:       return 32'(-ONE);
            default: return 32'(5 * ONE + z);
        endcase
    endfunction

    always @(posedge clk_in) begin
        sdf_done <= 1'b0;
        if (sdf_start) begin
            stub_cnt <= 4;
            stub_z   <= sdf_z;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else if (stub_cnt == 1) begin
            stub_cnt <= 0;
            sdf_done <= 1'b1;
            sdf_dist <= stub_dist(stub_mode, stub_z);
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_ray(input logic [31:0] o_z, input logic [31:0] d_z, input int mode,
                           input exp_t e, input bit poke);
        logic        prev, waiting, done, poked;
        logic [95:0] pt;
        exp_t        got;
        stub_mode = mode;
        ox = '0; oy = '0; oz = o_z;
        dx = '0; dy = '0; dz = d_z;
        sb.push_back(e);
        march_start = 1'b1;
        @(negedge clk_in);
        march_start = 1'b0;
        prev = 1'b0; waiting = 1'b0; done = 1'b0; poked = 1'b0; pt = '0;
        for (int c = 0; c < 2000 && !done; c++) begin
            if (sdf_start) begin
                chk("start_width", 96'(prev), 96'(0));
                pt = {sdf_x, sdf_y, sdf_z};
                waiting = 1'b1;
            end else if (waiting) begin
                chk("point_stable", {sdf_x, sdf_y, sdf_z}, pt);
            end
            if (sdf_done) waiting = 1'b0;
            if (poke && waiting && !sdf_start && !poked) begin
                march_start = 1'b1;
                poked = 1'b1;
            end else begin
                march_start = 1'b0;
            end
            prev = sdf_start;
            if (march_done) begin
                chk("sb_nonempty", 96'(sb.size() != 0), 96'(1));
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    chk("hit", 96'(hit), 96'(got.hit));
                    chk("t_out", 96'(t_out), 96'(got.t));
                    chk("steps_out", 96'(steps_out), 96'(got.steps));
                    chk("colour", 96'({red_out, green_out, blue_out}), 96'(got.col));
                end
                done = 1'b1;
            end
            @(negedge clk_in);
        end
        march_start = 1'b0;
        if (!done) chk("timeout", 96'(0), 96'(1));
        else chk("single_done", 96'(march_done), 96'(0));
    endtask

    initial begin
        logic any_done, any_start, stub_fired;
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        chk("rst_march_done", 96'(march_done), 96'(0));
        chk("rst_sdf_start", 96'(sdf_start), 96'(0));
        chk("rst_hit", 96'(hit), 96'(0));
        chk("rst_t_out", 96'(t_out), 96'(0));
        chk("rst_steps_out", 96'(steps_out), 96'(0));
        chk("rst_point", {sdf_x, sdf_y, sdf_z}, 96'(0));
        chk("rst_colour", 96'({red_out, green_out, blue_out}), 96'(0));
        rst_in = 1'b0;
        @(negedge clk_in);

        run_ray(32'(0), 32'(ONE), 0, '{hit: 1'b1, t: 32'd327680, steps: 8'd2, col: STUB_COL}, 1'b1);
        run_ray(32'(0), 32'(ONE), 1, '{hit: 1'b0, t: 32'd1376256, steps: 8'd7, col: BG_COL}, 1'b0);
        run_ray(32'(0), 32'(ONE), 2, '{hit: 1'b0, t: 32'd5240, steps: 8'd8, col: BG_COL}, 1'b1);
        run_ray(32'(0), 32'(ONE), 3, '{hit: 1'b1, t: 32'd0, steps: 8'd1, col: STUB_COL}, 1'b0);
        run_ray(32'(0), 32'(-ONE), 4, '{hit: 1'b1, t: 32'd327680, steps: 8'd2, col: STUB_COL}, 1'b0);
        run_ray(32'(ONE), 32'(ONE), 0, '{hit: 1'b1, t: 32'd262144, steps: 8'd2, col: STUB_COL}, 1'b0);
        chk("sb_drained", 96'(sb.size()), 96'(0));

        stub_mode = 0;
        oz = '0; dz = 32'(ONE);
        march_start = 1'b1;
        @(negedge clk_in);
        march_start = 1'b0;
        for (int c = 0; c < 20 && !sdf_start; c++) @(negedge clk_in);
        chk("wait_reached", 96'(sdf_start), 96'(1));
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        any_done = 1'b0; any_start = 1'b0; stub_fired = 1'b0;
        for (int c = 0; c < 12; c++) begin
            any_done   |= march_done;
            any_start  |= sdf_start;
            stub_fired |= sdf_done;
            @(negedge clk_in);
        end
        chk("stub_fired_after_reset", 96'(stub_fired), 96'(1));
        chk("no_done_after_reset", 96'(any_done), 96'(0));
        chk("no_start_after_reset", 96'(any_start), 96'(0));
        chk("rst_mid_t_out", 96'(t_out), 96'(0));
        chk("rst_mid_hit", 96'(hit), 96'(0));

        run_ray(32'(0), 32'(ONE), 0, '{hit: 1'b1, t: 32'd327680, steps: 8'd2, col: STUB_COL}, 1'b0);
        chk("sb_final", 96'(sb.size()), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
